// File: rtl/duty_modulator_if.sv
// duty_modulator_if: bit handshake between a bit source and duty_modulator.
// master offers bits; slave accepts them and reports progress.
interface duty_modulator_if;
  logic bit_valid;
  logic bit_data;
  logic bit_ready;
  logic busy;
  logic bit_done;

  modport master (
    output bit_valid,
    output bit_data,
    input  bit_ready,
    input  busy,
    input  bit_done
  );

  modport slave (
    input  bit_valid,
    input  bit_data,
    output bit_ready,
    output busy,
    output bit_done
  );
endinterface

// File: rtl/duty_modulator.sv
// duty_modulator: kick/level duty-cycle modulation of data bits on a SWIPT link.
// Optional DUTY_MOD_SLEW_EN limits duty_cycle steps to SLEW_STEP per cycle.
module duty_modulator #(
  parameter int DW        = 12,
  parameter int DMAX      = 500,
  parameter int CW        = 20,
  parameter int KICK_CYC  = 12288,
  parameter int BIT_CYC   = 49152,
  parameter int SLEW_STEP = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          swipt_alive,
  input  logic [1:0]    prog,
  input  logic [DW-1:0] l,
  duty_modulator_if.slave bus,
  output logic [DW-1:0] duty_cycle
);

  localparam int AW = DW + 2;
  localparam logic [AW-1:0] DMAX_W = AW'(DMAX);

  typedef enum logic [1:0] {
    IDLE,
    KICK,
    LEVEL
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic [CW-1:0] kick_cnt, kick_cnt_nx;
  logic          cur_bit, cur_bit_nx;
  logic          hist, hist_nx;

  logic [AW-1:0] lc, l_w;
  logic [AW-1:0] c2, c3, c4;
  logic [AW-1:0] lvl0, lvl1;
  logic [AW-1:0] target, duty_nx;
  logic          en, last, accept, kick;

  always_comb begin
    l_w = {2'b00, l};
    lc  = (l_w < DMAX_W) ? l_w : DMAX_W;
    c2  = lc + lc / AW'(2);
    c3  = lc + lc / AW'(3);
    c4  = lc + lc / AW'(4);
    if (c2 < DMAX_W)      lvl0 = c2;
    else if (c3 < DMAX_W) lvl0 = c3;
    else if (c4 < DMAX_W) lvl0 = c4;
    else                  lvl0 = DMAX_W;
    // near the ceiling lc/3 would be a tiny swing; mirror below lc instead
    if ((DMAX_W - lc) < lc / AW'(5))
      lvl1 = (lc << 1) - DMAX_W;
    else
      lvl1 = lc / AW'(3);
  end

  always_comb begin
    en     = swipt_alive && (prog == 2'b11);
    last   = (state == LEVEL) && (bit_cnt == CW'(BIT_CYC - 1));
    kick   = !hist || (bus.bit_data != cur_bit);

    bus.bit_ready = !rst && en && ((state == IDLE) || last);
    bus.busy      = !rst && (state != IDLE);
    bus.bit_done  = !rst && en && last;
    accept        = bus.bit_valid && bus.bit_ready;

    state_nx    = state;
    bit_cnt_nx  = bit_cnt + CW'(1);
    kick_cnt_nx = kick_cnt;
    cur_bit_nx  = cur_bit;
    hist_nx     = hist;

    unique case (state)
      IDLE: bit_cnt_nx = '0;
      KICK: begin
        kick_cnt_nx = kick_cnt + CW'(1);
        if (kick_cnt == CW'(KICK_CYC - 1))
          state_nx = LEVEL;
      end
      LEVEL: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (accept) begin
      state_nx    = kick ? KICK : LEVEL;
      bit_cnt_nx  = '0;
      kick_cnt_nx = '0;
      cur_bit_nx  = bus.bit_data;
      hist_nx     = 1'b1;
    end

    if (!en) begin
      state_nx    = IDLE;
      bit_cnt_nx  = '0;
      kick_cnt_nx = '0;
      hist_nx     = 1'b0;
    end
  end

  // target follows the next state so an accept shows on duty_cycle one cycle later
  always_comb begin
    unique case (state_nx)
      KICK:    target = cur_bit_nx ? '0 : DMAX_W;
      LEVEL:   target = cur_bit_nx ? lvl1 : lvl0;
      default: target = lc;
    endcase
  end

`ifdef DUTY_MOD_SLEW_EN
  logic [AW-1:0] duty_w;

  always_comb begin
    duty_w = {2'b00, duty_cycle};
    if (target > duty_w + AW'(SLEW_STEP))
      duty_nx = duty_w + AW'(SLEW_STEP);
    else if (target + AW'(SLEW_STEP) < duty_w)
      duty_nx = duty_w - AW'(SLEW_STEP);
    else
      duty_nx = target;
  end
`else
  always_comb begin
    duty_nx = target;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      kick_cnt   <= '0;
      cur_bit    <= 1'b0;
      hist       <= 1'b0;
      duty_cycle <= DW'(lc);
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      kick_cnt   <= kick_cnt_nx;
      cur_bit    <= cur_bit_nx;
      hist       <= hist_nx;
      duty_cycle <= DW'(duty_nx);
    end
  end

endmodule

// File: tb/tb_duty_modulator.sv
// tb_duty_modulator: directed and random bits against a per-bit schedule model.
// Expected duty comes from the kick/level rules applied to a queue of bit slots.
module tb_duty_modulator;

  localparam int DW   = 12;
  localparam int DMAX = 500;
  localparam int KC   = 4;
  localparam int BC   = 16;
  localparam int STEP = 8;

  logic          clk;
  logic          rst;
  logic          alive;
  logic [1:0]    prog;
  logic [DW-1:0] l;
  logic [DW-1:0] duty_cycle;

  duty_modulator_if bus ();

  duty_modulator #(
    .DW(DW), .DMAX(DMAX), .CW(20),
    .KICK_CYC(KC), .BIT_CYC(BC), .SLEW_STEP(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .swipt_alive(alive),
    .prog(prog),
    .l(l),
    .bus(bus),
    .duty_cycle(duty_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit kick;
    bit val;
    bit last;
  } slot_t;

  slot_t sched[$];
  int    total = 0;
  int    bad = 0;
  int    exp_duty;
  bit    has_prev;
  bit    prev_bit;
  bit    last_acc;

  function automatic int lcf(int lv);
    return (lv < DMAX) ? lv : DMAX;
  endfunction

  function automatic int lvl(bit b, int lv);
    int c;
    c = lcf(lv);
    if (!b) begin
      for (int k = 2; k <= 4; k++)
        if (c + c / k < DMAX) return c + c / k;
      return DMAX;
    end
    return ((DMAX - c) < c / 5) ? 2 * c - DMAX : c / 3;
  endfunction

  function automatic int slew(int cur, int tgt);
    int r;
    r = tgt;
`ifdef DUTY_MOD_SLEW_EN
    if (tgt > cur + STEP) r = cur + STEP;
    else if (tgt < cur - STEP) r = cur - STEP;
`else
    if (cur < 0) r = tgt;
`endif
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // one cycle: inputs already driven after a negedge
  task automatic step();
    bit en, rdy, dn, bz, kk;
    int tgt;
    #1;
    en  = alive && (prog == 2'b11);
    bz  = !rst && (sched.size() > 0);
    dn  = !rst && en && (sched.size() > 0) && sched[0].last;
    rdy = !rst && en && ((sched.size() == 0) || sched[0].last);
    chk("duty", {20'd0, duty_cycle}, exp_duty);
    chk("ready", {31'd0, bus.bit_ready}, {31'd0, rdy});
    chk("busy", {31'd0, bus.busy}, {31'd0, bz});
    chk("done", {31'd0, bus.bit_done}, {31'd0, dn});
    last_acc = bus.bit_valid && rdy;
    if (rst || !en) begin
      sched.delete();
      has_prev = 1'b0;
    end else begin
      if (sched.size() > 0) sched.delete(0);
      if (last_acc) begin
        kk = !has_prev || (bus.bit_data != prev_bit);
        for (int i = 0; i < BC; i++)
          sched.push_back('{kick: (kk && i < KC),
                            val: bus.bit_data,
                            last: (i == BC - 1)});
        has_prev = 1'b1;
        prev_bit = bus.bit_data;
      end
    end
    if (sched.size() == 0) tgt = lcf(int'(l));
    else if (sched[0].kick) tgt = sched[0].val ? 0 : DMAX;
    else tgt = lvl(sched[0].val, int'(l));
    exp_duty = rst ? lcf(int'(l)) : slew(exp_duty, tgt);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(bit d);
    int guard;
    bus.bit_valid = 1'b1;
    bus.bit_data  = d;
    last_acc = 1'b0;
    guard = 0;
    while (!last_acc && guard < 3 * BC) begin
      step();
      guard++;
    end
    chk("accept", {31'd0, last_acc}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    alive = 1'b1;
    prog = 2'b11;
    l = 12'd200;
    bus.bit_valid = 1'b0;
    bus.bit_data = 1'b0;
    has_prev = 1'b0;
    prev_bit = 1'b0;
    last_acc = 1'b0;
    @(negedge clk);
    exp_duty = lcf(int'(l));
    run(2);
    rst = 1'b0;
    run(2);

    send(1'b0);
    send(1'b0);
    send(1'b1);
    bus.bit_valid = 1'b0;
    run(BC + 2);

    l = 12'd400;
    send(1'b0);
    send(1'b1);
    bus.bit_valid = 1'b0;
    run(BC + 1);
    l = 12'd450;
    send(1'b1);
    bus.bit_valid = 1'b0;
    run(BC + 1);

    l = 12'd200;
    send(1'b0);
    bus.bit_valid = 1'b0;
    run(6);
    alive = 1'b0;
    step();
    alive = 1'b1;
    run(2);
    send(1'b0);
    bus.bit_valid = 1'b0;
    run(5);
    l = 12'd300;
    run(BC);

    send(1'b1);
    bus.bit_valid = 1'b0;
    run(2);
    rst = 1'b1;
    l = 12'd3000;
    run(2);
    rst = 1'b0;
    l = 12'd120;
    send(1'b1);
    bus.bit_valid = 1'b0;
    run(3);
    prog = 2'b01;
    run(2);
    prog = 2'b11;
    run(2);

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 7) == 0)
        l = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 4095))
                                        : DW'($urandom_range(0, 600));
      bus.bit_valid = ($urandom_range(0, 2) != 0);
      bus.bit_data  = 1'($urandom_range(0, 1));
      alive = ($urandom_range(0, 59) != 0);
      prog  = ($urandom_range(0, 69) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      rst   = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;
    alive = 1'b1;
    prog = 2'b11;
    bus.bit_valid = 1'b0;
    run(BC + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/duty_modulator.md
DUTY_MODULATOR -- requirements
Module: duty_modulator

Interface
REQ-001 Parameter DW, default 12: width of l and duty_cycle.
REQ-002 Parameter DMAX, default 500: maximum duty value; every duty output is clamped to it.
REQ-003 Parameter CW, default 20: width of the internal kick and bit counters.
REQ-004 Parameter KICK_CYC, default 12288: kick length in clk cycles; SHALL satisfy 1 <= KICK_CYC < BIT_CYC.
REQ-005 Parameter BIT_CYC, default 49152: total length of one bit in clk cycles; SHALL satisfy BIT_CYC < 2^CW.
REQ-006 Parameter SLEW_STEP, default 8: maximum change of duty_cycle per cycle; used only with DUTY_MOD_SLEW_EN.
REQ-007 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-008 Port rst, input, 1: synchronous, active-high reset.
REQ-009 Port swipt_alive, input, 1: power link up; low aborts any modulation.
REQ-010 Port program, input, 2: mode select; only 2'b11 enables data modulation.
REQ-011 Port l, input, DW: base duty cycle.
REQ-012 Port bit_valid, input, 1: bit_data is offered.
REQ-013 Port bit_data, input, 1: bit value to transmit.
REQ-014 Port bit_ready, output, 1: a bit is accepted when bit_valid and bit_ready are both high.
REQ-015 Port duty_cycle, output, DW: registered duty command.
REQ-016 Port busy, output, 1: a bit is in progress.
REQ-017 Port bit_done, output, 1: one-cycle pulse in the last cycle of a completed bit.

Function
REQ-018 lc SHALL be min(l, DMAX); all arithmetic SHALL be done at DW+2 bits with truncating division.
REQ-019 The bit-0 level SHALL be the first of lc+lc/2, lc+lc/3, lc+lc/4 that is strictly less than DMAX; if none is, the level SHALL be DMAX.
REQ-020 The bit-1 level SHALL be 2*lc-DMAX if (DMAX-lc) < lc/5, otherwise lc/3.
REQ-021 The bit-0 kick value SHALL be DMAX; the bit-1 kick value SHALL be 0.
REQ-022 The FSM SHALL have three states: IDLE, KICK and LEVEL.
REQ-023 IDLE: target = lc; bit_ready = 1 only when program==2'b11 and swipt_alive==1.
REQ-024 On accept in IDLE: if no bit has been sent since reset/abort, or bit_data differs from the previously sent bit, the FSM SHALL go to KICK, otherwise to LEVEL.
REQ-025 On accept, the bit counter SHALL be cleared and the accepted bit value registered.
REQ-026 KICK: target = kick value for KICK_CYC cycles, then LEVEL.
REQ-027 LEVEL: target = level value until the bit counter reaches BIT_CYC-1.
REQ-028 A non-kicked bit SHALL last exactly BIT_CYC cycles in LEVEL; a kicked bit SHALL last exactly BIT_CYC cycles across KICK and LEVEL.
REQ-029 In the last cycle of a bit, bit_done=1 and bit_ready=1 (when REQ-023 conditions hold).
REQ-030 An accept in the last cycle of a bit SHALL start the next bit on the following cycle with no IDLE gap; otherwise the FSM SHALL return to IDLE.
REQ-031 Without DUTY_MOD_SLEW_EN, duty_cycle SHALL equal the target registered one cycle later; an accept at cycle N gives the new value at N+1.
REQ-032 Levels SHALL track l live during LEVEL.
REQ-033 busy SHALL be 1 in KICK and LEVEL and 0 in IDLE.
REQ-034 Abort: if swipt_alive==0 or program!=2'b11 in any state, the next cycle SHALL have FSM=IDLE, target=lc, no bit_done and the previous-bit history cleared.
REQ-035 bit_valid without bit_ready SHALL be ignored; bit_data SHALL be sampled only on accept.

Reset
REQ-036 While rst=1: FSM=IDLE, counters=0, history cleared, bit_ready=0, busy=0, bit_done=0, and duty_cycle=min(l,DMAX) on each clock.
REQ-037 rst SHALL take priority over every other input.

Configuration
REQ-038 With DUTY_MOD_SLEW_EN defined, duty_cycle SHALL step toward the target by at most SLEW_STEP per cycle and SHALL land exactly on the target; reset SHALL still load min(l,DMAX) directly.
REQ-039 Without DUTY_MOD_SLEW_EN, the behaviour SHALL be REQ-031 and SLEW_STEP SHALL be unused.

Verification
REQ-040 (DW=12, DMAX=500, KICK_CYC=4, BIT_CYC=16, l=200) bit 0 after reset -> duty_cycle=500 for 4 cycles, then 300 for 12 cycles, bit_done pulses in cycle 16.
REQ-041 Back-to-back 0,0,1 with accept in each last cycle -> second bit 300 for 16 cycles (no kick); third bit 0 for 4 cycles then 66 for 12; no IDLE gap.
REQ-042 l=400, bit 0 then 1 -> level 500 (clamp), then kick 0 and level 133; l=450, bit 1 -> level 400.
REQ-043 swipt_alive dropped at cycle 7 of a bit -> next cycle duty_cycle=l, busy=0, no bit_done; the next bit 0 kicks again.
REQ-044 rst asserted during KICK -> next cycle IDLE, duty_cycle=min(l,500), bit_ready=0 while rst is high.
REQ-045 DUTY_MOD_SLEW_EN, SLEW_STEP=8, l=200, bit 1 -> duty_cycle goes 192, 184, ... toward 0, never jumps more than 8 per cycle.
